// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the TMR fault monitor slice.
//   fm_state_e  : fault monitor controller states
//   FM_NREPLICA : number of ALU replicas tracked by the monitor
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    FM_MONITOR  = 2'd0,
    FM_DRAIN    = 2'd1,
    FM_DEGRADED = 2'd2
  } fm_state_e;

  localparam int FM_NREPLICA = 3;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up/down error counter, one per ALU replica.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (highest priority after rst)
//   inc      : increment, saturating at MAX
//   dec      : decrement, floored at zero (ignored when inc is set)
//   cnt      : registered count
module cv32e40p_sat_counter #(
  parameter int CNT_W = 16,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc) begin
      if (cnt_reg < MAX_V) begin
        cnt_next = cnt_reg + ONE_V;
      end
    end else if (dec) begin
      if (cnt_reg != '0) begin
        cnt_next = cnt_reg - ONE_V;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// Fault-tracking controller behind the triplicated ALU's majority voters.
// Keeps a leaky saturating error count per replica, and once a replica
// reaches THRESHOLD waits for EX to be ready before swapping in the spare.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   valid_i             : voter flags meaningful this cycle
//   err_a/b/c_i         : per-voter mismatch flags for replica 0/1/2
//   ex_ready_i          : EX stage ready (safe switch point)
//   clear_i             : software re-arm
//   spare_sel_o         : one-hot spare routing select
//   faulted_o           : a replica has been replaced
//   fault_id_o          : replaced or pending replica index
//   multi_err_o         : pulse when >=2 replicas flagged in one cycle
//   double_fault_o      : sticky, error seen while degraded
//   err_cnt_o           : error counters packed {c,b,a}
module cv32e40p_tmr_fault_monitor
  import cv32e40p_pkg::*;
#(
  parameter int NVOTER      = 3,
  parameter int CNT_W       = 16,
  parameter int THRESHOLD   = 4,
  parameter int LEAK_PERIOD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [NVOTER-1:0]  err_a_i,
  input  logic [NVOTER-1:0]  err_b_i,
  input  logic [NVOTER-1:0]  err_c_i,
  input  logic               ex_ready_i,
  input  logic               clear_i,
  output logic [2:0]         spare_sel_o,
  output logic               faulted_o,
  output logic [1:0]         fault_id_o,
  output logic               multi_err_o,
  output logic               double_fault_o,
  output logic [3*CNT_W-1:0] err_cnt_o
);

  localparam int LEAK_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD + 1) : 1;
  localparam logic [LEAK_W-1:0] LEAK_LAST = (LEAK_PERIOD > 0) ? LEAK_W'(LEAK_PERIOD - 1) : '0;
  localparam logic [LEAK_W-1:0] LEAK_ONE  = LEAK_W'(1);
  localparam logic [CNT_W-1:0]  THR_M1    = CNT_W'(THRESHOLD - 1);

  fm_state_e state_reg, state_next;
  logic [LEAK_W-1:0] leak_reg, leak_next;
  logic [2:0]        spare_reg, spare_next;
  logic              faulted_reg, faulted_next;
  logic [1:0]        fault_id_reg, fault_id_next;
  logic              multi_reg, multi_next;
  logic              double_reg, double_next;

  logic [FM_NREPLICA-1:0] e_vec;
  logic [FM_NREPLICA-1:0] hit_vec;
  logic [FM_NREPLICA-1:0] inc_vec;
  logic [FM_NREPLICA-1:0] sel_vec;
  logic                   dec_all;
  logic                   multi_flag;
  logic                   single_flag;
  logic [1:0]             e_id;
  logic [CNT_W-1:0]       cnt [FM_NREPLICA];

  assign e_vec[0] = valid_i & (|err_a_i);
  assign e_vec[1] = valid_i & (|err_b_i);
  assign e_vec[2] = valid_i & (|err_c_i);

  assign multi_flag  = (e_vec[0] & e_vec[1]) | (e_vec[0] & e_vec[2]) | (e_vec[1] & e_vec[2]);
  assign single_flag = (|e_vec) & ~multi_flag;
  // Only meaningful when exactly one flag is set.
  assign e_id = e_vec[2] ? 2'd2 : (e_vec[1] ? 2'd1 : 2'd0);

  for (genvar gi = 0; gi < FM_NREPLICA; gi++) begin : g_replica
    // This replica's increment would land exactly on THRESHOLD.
    assign hit_vec[gi] = e_vec[gi] & (cnt[gi] == THR_M1);
    assign sel_vec[gi] = (fault_id_reg == 2'(gi));

    cv32e40p_sat_counter #(
      .CNT_W (CNT_W),
      .MAX   (THRESHOLD)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clear_i),
      .inc (inc_vec[gi]),
      .dec (dec_all),
      .cnt (cnt[gi])
    );
  end

  always_comb begin
    state_next    = state_reg;
    leak_next     = leak_reg;
    spare_next    = spare_reg;
    faulted_next  = faulted_reg;
    fault_id_next = fault_id_reg;
    double_next   = double_reg;
    multi_next    = 1'b0;
    inc_vec       = '0;
    dec_all       = 1'b0;

    case (state_reg)
      FM_MONITOR: begin
        if (multi_flag) begin
          multi_next = 1'b1;
          leak_next  = '0;
        end else if (single_flag) begin
          inc_vec   = e_vec;
          leak_next = '0;
          if (|hit_vec) begin
            state_next    = FM_DRAIN;
            fault_id_next = e_id;
          end
        end else if (valid_i && (LEAK_PERIOD != 0)) begin
          if (leak_reg == LEAK_LAST) begin
            dec_all   = 1'b1;
            leak_next = '0;
          end else begin
            leak_next = leak_reg + LEAK_ONE;
          end
        end
      end
      FM_DRAIN: begin
        if (ex_ready_i) begin
          spare_next   = sel_vec;
          faulted_next = 1'b1;
          state_next   = FM_DEGRADED;
        end
      end
      FM_DEGRADED: begin
        if (|e_vec) begin
          double_next = 1'b1;
        end
      end
      default: begin
        state_next = FM_MONITOR;
      end
    endcase

    // Re-arm wins over anything the flags requested this cycle.
    if (clear_i) begin
      state_next    = FM_MONITOR;
      leak_next     = '0;
      spare_next    = '0;
      faulted_next  = 1'b0;
      fault_id_next = '0;
      double_next   = 1'b0;
      multi_next    = 1'b0;
      inc_vec       = '0;
      dec_all       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FM_MONITOR;
      leak_reg     <= '0;
      spare_reg    <= '0;
      faulted_reg  <= 1'b0;
      fault_id_reg <= '0;
      multi_reg    <= 1'b0;
      double_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      leak_reg     <= leak_next;
      spare_reg    <= spare_next;
      faulted_reg  <= faulted_next;
      fault_id_reg <= fault_id_next;
      multi_reg    <= multi_next;
      double_reg   <= double_next;
    end
  end

  assign spare_sel_o    = spare_reg;
  assign faulted_o      = faulted_reg;
  assign fault_id_o     = fault_id_reg;
  assign multi_err_o    = multi_reg;
  assign double_fault_o = double_reg;
  assign err_cnt_o      = {cnt[2], cnt[1], cnt[0]};

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
module tb_cv32e40p_tmr_fault_monitor;

  localparam int CNT_W = 16;

  logic              clk;
  logic              rst;
  logic              valid_i;
  logic [2:0]        err_a_i;
  logic [2:0]        err_b_i;
  logic [2:0]        err_c_i;
  logic              ex_ready_i;
  logic              clear_i;
  logic [2:0]        spare_sel_o;
  logic              faulted_o;
  logic [1:0]        fault_id_o;
  logic              multi_err_o;
  logic              double_fault_o;
  logic [3*CNT_W-1:0] err_cnt_o;

  int checks;
  int failures;

  cv32e40p_tmr_fault_monitor #(
    .NVOTER      (3),
    .CNT_W       (CNT_W),
    .THRESHOLD   (4),
    .LEAK_PERIOD (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .err_a_i        (err_a_i),
    .err_b_i        (err_b_i),
    .err_c_i        (err_c_i),
    .ex_ready_i     (ex_ready_i),
    .clear_i        (clear_i),
    .spare_sel_o    (spare_sel_o),
    .faulted_o      (faulted_o),
    .fault_id_o     (fault_id_o),
    .multi_err_o    (multi_err_o),
    .double_fault_o (double_fault_o),
    .err_cnt_o      (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let outputs settle 1ns past the edge.
  task automatic step(input logic v, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] c, input logic exr, input logic clr);
    valid_i    = v;
    err_a_i    = a;
    err_b_i    = b;
    err_c_i    = c;
    ex_ready_i = exr;
    clear_i    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 3'b0, 3'b0, 3'b0, 1'b0, 1'b0);
    step(1'b0, 3'b0, 3'b0, 3'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3*CNT_W+7:0] all_out;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'b0);
    end
    all_out = {spare_sel_o, faulted_o, fault_id_o, multi_err_o, double_fault_o, err_cnt_o};
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    checks++;
    if (err_cnt_o !== '0) begin
      failures++;
      $display("FAIL reset_err_cnt got=%h exp=0", err_cnt_o);
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_threshold_switch();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 3'b000, 3'b001, 3'b000, 1'b1, 1'b0);
      checks++;
      if (err_cnt_o !== {16'd0, 16'(i), 16'd0}) begin
        failures++;
        $display("FAIL thr_cnt_b step=%0d got=%h exp=%h", i, err_cnt_o, {16'd0, 16'(i), 16'd0});
      end
    end
    // In FM_DRAIN: fault id latched, spare not yet switched.
    checks++;
    if ({spare_sel_o, faulted_o, fault_id_o} !== {3'b000, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL thr_drain got sel=%b flt=%b id=%0d exp sel=000 flt=0 id=1",
               spare_sel_o, faulted_o, fault_id_o);
    end
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    checks++;
    if ({spare_sel_o, faulted_o, fault_id_o} !== {3'b010, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL thr_switch got sel=%b flt=%b id=%0d exp sel=010 flt=1 id=1",
               spare_sel_o, faulted_o, fault_id_o);
    end
    $display("test_threshold_switch done");
  endtask

  task automatic test_leak();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
      if (i == 7) begin
        checks++;
        if (err_cnt_o !== {16'd0, 16'd0, 16'd3}) begin
          failures++;
          $display("FAIL leak_before got=%h exp=%h", err_cnt_o, {16'd0, 16'd0, 16'd3});
        end
      end
    end
    checks++;
    if (err_cnt_o !== {16'd0, 16'd0, 16'd2}) begin
      failures++;
      $display("FAIL leak_after got=%h exp=%h", err_cnt_o, {16'd0, 16'd0, 16'd2});
    end
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    checks++;
    if (err_cnt_o !== {16'd0, 16'd0, 16'd2}) begin
      failures++;
      $display("FAIL leak_invalid_hold got=%h exp=%h", err_cnt_o, {16'd0, 16'd0, 16'd2});
    end
    for (int i = 0; i < 2; i++) step(1'b1, 3'b010, 3'b000, 3'b000, 1'b1, 1'b0);
    checks++;
    if ({err_cnt_o, fault_id_o, spare_sel_o} !== {16'd0, 16'd0, 16'd4, 2'd0, 3'b000}) begin
      failures++;
      $display("FAIL leak_drain got cnt=%h id=%0d sel=%b exp cnt=4 id=0 sel=000",
               err_cnt_o, fault_id_o, spare_sel_o);
    end
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    checks++;
    if ({spare_sel_o, faulted_o} !== {3'b001, 1'b1}) begin
      failures++;
      $display("FAIL leak_switch got sel=%b flt=%b exp sel=001 flt=1", spare_sel_o, faulted_o);
    end
    $display("test_leak done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0);
    step(1'b1, 3'b001, 3'b000, 3'b010, 1'b1, 1'b0);
    checks++;
    if (multi_err_o !== 1'b1) begin
      failures++;
      $display("FAIL multi_pulse got=%b exp=1", multi_err_o);
    end
    checks++;
    if (err_cnt_o !== {16'd0, 16'd0, 16'd1}) begin
      failures++;
      $display("FAIL multi_cnt got=%h exp=%h", err_cnt_o, {16'd0, 16'd0, 16'd1});
    end
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    checks++;
    if (multi_err_o !== 1'b0) begin
      failures++;
      $display("FAIL multi_one_cycle got=%b exp=0", multi_err_o);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_drain_stall();
    // Mid-stall reset aborts the pending switch.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0);
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    rst = 1'b0;
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    checks++;
    if ({spare_sel_o, faulted_o, fault_id_o, multi_err_o, double_fault_o, err_cnt_o} !== '0) begin
      failures++;
      $display("FAIL stall_rst got sel=%b flt=%b id=%0d cnt=%h exp all 0",
               spare_sel_o, faulted_o, fault_id_o, err_cnt_o);
    end

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0);
    checks++;
    if (fault_id_o !== 2'd2) begin
      failures++;
      $display("FAIL stall_id got=%0d exp=2", fault_id_o);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
      checks++;
      if (spare_sel_o !== 3'b000) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got=%b exp=000", i, spare_sel_o);
      end
    end
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    checks++;
    if ({spare_sel_o, faulted_o} !== {3'b100, 1'b1}) begin
      failures++;
      $display("FAIL stall_switch got sel=%b flt=%b exp sel=100 flt=1", spare_sel_o, faulted_o);
    end
    $display("test_drain_stall done");
  endtask

  // Continues from the degraded state left by test_drain_stall (replica c).
  task automatic test_degraded_clear();
    step(1'b1, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0);
    checks++;
    if (double_fault_o !== 1'b1) begin
      failures++;
      $display("FAIL deg_double got=%b exp=1", double_fault_o);
    end
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    checks++;
    if ({double_fault_o, spare_sel_o, fault_id_o, err_cnt_o} !== {1'b1, 3'b100, 2'd2, 16'd4, 16'd0, 16'd0}) begin
      failures++;
      $display("FAIL deg_sticky got dbl=%b sel=%b id=%0d cnt=%h exp dbl=1 sel=100 id=2 cnt=c:4",
               double_fault_o, spare_sel_o, fault_id_o, err_cnt_o);
    end
    step(1'b1, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1);
    checks++;
    if ({spare_sel_o, faulted_o, fault_id_o, multi_err_o, double_fault_o, err_cnt_o} !== '0) begin
      failures++;
      $display("FAIL clear_outputs got sel=%b flt=%b id=%0d dbl=%b cnt=%h exp all 0",
               spare_sel_o, faulted_o, fault_id_o, double_fault_o, err_cnt_o);
    end
    // Back in FM_MONITOR: a single error counts again.
    step(1'b1, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0);
    checks++;
    if ({err_cnt_o, double_fault_o} !== {16'd0, 16'd0, 16'd1, 1'b0}) begin
      failures++;
      $display("FAIL clear_monitor got cnt=%h dbl=%b exp cnt=a:1 dbl=0", err_cnt_o, double_fault_o);
    end
    $display("test_degraded_clear done");
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    valid_i    = 1'b0;
    err_a_i    = '0;
    err_b_i    = '0;
    err_c_i    = '0;
    ex_ready_i = 1'b0;
    clear_i    = 1'b0;
    test_reset();
    test_threshold_switch();
    test_leak();
    test_simultaneous();
    test_drain_stall();
    test_degraded_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_fault_monitor.md
# cv32e40p_tmr_fault_monitor

Fault-tracking controller placed directly downstream of the triplicated ALU's majority voters. It consumes the per-replica mismatch flags from the result, comparison and ready voters, and keeps a leaky saturating error count per replica. When a replica is judged permanently faulty, the controller waits for a pipeline-safe point and then drives the one-hot select that swaps the spare ALU in for that replica. In degraded mode it reports any further fault as a double fault.

## Interface
- `NVOTER`, 3: number of voters whose flags are ORed per replica.
- `CNT_W`, 16: width of each error counter.
- `THRESHOLD`, 4: count at which a replica is declared faulty. Must be at least 1 and at most 2^CNT_W-1.
- `LEAK_PERIOD`, 8: clean valid cycles per leak decrement. 0 disables leaking.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `valid_i`  in  1  voter flags are meaningful this cycle (ALU `enable_i`).
- `err_a_i` / `err_b_i` / `err_c_i`  in  NVOTER each  voter mismatch flags for replica 0 / 1 / 2.
- `ex_ready_i`  in  1  EX stage ready; defines a safe switch point.
- `clear_i`  in  1  software re-arm.
- `spare_sel_o`  out  3  one-hot; bit k routes the spare into voter slot k.
- `faulted_o`  out  1  a replica has been replaced.
- `fault_id_o`  out  2  index of the replaced or pending replica.
- `multi_err_o`  out  1  single-cycle pulse when at least 2 replicas are flagged together.
- `double_fault_o`  out  1  sticky; error seen while degraded.
- `err_cnt_o`  out  3*CNT_W  counters packed {c,b,a}.

## Operation
- Per-replica flag: e_k = valid_i & |err_k_i.
- FSM states: FM_MONITOR, FM_DRAIN, FM_DEGRADED.

FM_MONITOR:
- Exactly one e_k set: cnt_k increments, saturating at THRESHOLD.
- Two or more set: no counter change; multi_err_o pulses.
- A valid cycle with no e_k advances the leak timer. On reaching LEAK_PERIOD, every nonzero counter decrements by 1 and the timer clears.
- Any e_k set clears the leak timer. Cycles with valid_i=0 hold the timer.
- When the post-increment cnt_k equals THRESHOLD: latch fault_id_o=k and go to FM_DRAIN. Only one counter can increment per cycle, so there are no ties.

FM_DRAIN:
- Counters and leak timer frozen; flags ignored.
- On ex_ready_i=1: set spare_sel_o[fault_id_o], set faulted_o, go to FM_DEGRADED.

FM_DEGRADED:
- spare_sel_o, fault_id_o and counters held.
- Any e_k sets double_fault_o, which stays set until clear_i or rst.

clear_i, in any state:
- Zeroes counters, leak timer, spare_sel_o, faulted_o, fault_id_o and double_fault_o.
- Returns the FSM to FM_MONITOR.
- Takes priority over same-cycle flags.

rst:
- Identical to clear_i, and also zeroes multi_err_o.
- All outputs are 0 out of reset.
- Reset during FM_DRAIN aborts the pending switch.

## Timing
- All outputs are registered. Inputs are combinational from the voters and are sampled at the rising edge of `clk`.
- A counter update is visible on err_cnt_o one cycle after the flagged cycle.
- The THRESHOLD-th error in cycle t puts the FSM in FM_DRAIN at cycle t+1. With ex_ready_i=1 at t+1, spare_sel_o is set at t+2, which is the minimum latency of 2 cycles.
- ex_ready_i low in FM_DRAIN stalls the switch indefinitely. spare_sel_o never changes while ex_ready_i=0.
- multi_err_o is high for exactly one cycle per offending input cycle.

## Structure
- Shared package cv32e40p_pkg holds:
  - typedef enum logic [1:0] fm_state_e {FM_MONITOR, FM_DRAIN, FM_DEGRADED};
  - localparam FM_NREPLICA = 3.
- Sub-module cv32e40p_sat_counter (CNT_W, MAX), with inc/dec/clr, instantiated once per replica.
- Leak timer and FSM live in the top module.

## Test plan
- Reset: assert rst for 2 cycles with random flags.
  - Required: all outputs 0, err_cnt_o=0.
- Threshold switch: 4 valid cycles with err_b_i=3'b001, ex_ready_i=1.
  - Required: cnt_b steps 1,2,3,4; FM_DRAIN next cycle; then spare_sel_o=3'b010, fault_id_o=1, faulted_o=1, two cycles after the 4th error.
- Leak: 3 errors on replica a, then 8 clean valid cycles.
  - Required: cnt_a=2.
  - Then 2 more errors: switch, spare_sel_o=3'b001.
  - Also: 8 cycles with valid_i=0 produce no decrement.
- Simultaneous flags: err_a_i and err_c_i set in the same valid cycle.
  - Required: multi_err_o=1 for exactly one cycle; counters unchanged.
- Drain stall: reach THRESHOLD on replica c with ex_ready_i=0 for 5 cycles, then 1.
  - Required: spare_sel_o=0 during the stall, 3'b100 the cycle after ex_ready_i rises.
  - Separately: rst mid-stall leaves all outputs 0.
- Degraded and clear: in FM_DEGRADED, flag replica a.
  - Required: double_fault_o=1 and sticky.
  - Then clear_i with err_a_i set in the same cycle: all outputs 0, FM_MONITOR, cnt_a=0.
